cr_clic_sel_claim: RTL and testbench

- Consumes the one-hot winner vector produced by the CLIC priority selection and encodes it to a binary interrupt ID.
- Registers the ID and its priority, then presents them to the core on a valid/ack claim handshake.
- On a claim, issues a one-cycle one-hot clear pulse back to the pending register array.
- Sits between the CLIC selection tree and the core interrupt interface; it is the receiving/decoding end of the one-hot select path.

---
 rtl/cr_clic_pkg.sv | 17 +
 rtl/cr_clic_onehot_enc.sv | 22 ++
 rtl/cr_clic_sel_claim.sv | 80 ++++++++
 tb/tb_cr_clic_sel_claim.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_clic_pkg.sv
// Shared CLIC claim-path definitions: FSM encoding, default sizes, ID width derivation.
package cr_clic_pkg;

  localparam int CLIC_WIDTH  = 32;
  localparam int CLIC_PRIO_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PEND  = 2'b01,
    ST_CLEAR = 2'b10
  } clic_state_e;

  function automatic int id_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/cr_clic_onehot_enc.sv
// One-hot to binary OR-encoder with zero / multi-hot detection.
module cr_clic_onehot_enc import cr_clic_pkg::*; #(
  parameter int WIDTH = CLIC_WIDTH,
  parameter int ID_W  = id_w(WIDTH)
) (
  input  logic [WIDTH-1:0] onehot,
  output logic [ID_W-1:0]  id,
  output logic             zero,
  output logic             multi
);

  // Pure OR tree: a multi-hot vector yields the OR of its indices.
  always_comb begin
    id = '0;
    for (int i = 0; i < WIDTH; i++)
      if (onehot[i]) id = id | ID_W'(i);
  end

  assign zero  = ~|onehot;
  assign multi = |(onehot & (onehot - WIDTH'(1)));

endmodule

// File: rtl/cr_clic_sel_claim.sv
// Registers the CLIC winner, presents it on a valid/ack claim handshake and
// issues a one-cycle pending-clear pulse on each claim.
module cr_clic_sel_claim import cr_clic_pkg::*; #(
  parameter int WIDTH  = CLIC_WIDTH,
  parameter int ID_W   = id_w(WIDTH),
  parameter int PRIO_W = CLIC_PRIO_W
) (
  input  logic              clic_clk,
  input  logic              clic_rst,
  input  logic              sel_vld,
  input  logic [WIDTH-1:0]  sel_onehot,
  input  logic [PRIO_W-1:0] sel_prio,
  input  logic              core_int_ack,
  output logic              int_vld,
  output logic [ID_W-1:0]   int_id,
  output logic [PRIO_W-1:0] int_prio,
  output logic [WIDTH-1:0]  pend_clr_onehot,
  output logic              onehot_err
);

  clic_state_e      state, state_nxt;
  logic [WIDTH-1:0] hold_oh;
  logic [ID_W-1:0]  enc_id;
  logic             enc_zero, enc_multi;
  logic             cap;

  cr_clic_onehot_enc #(.WIDTH(WIDTH), .ID_W(ID_W)) u_enc (
    .onehot (sel_onehot),
    .id     (enc_id),
    .zero   (enc_zero),
    .multi  (enc_multi)
  );

  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sel_vld && !enc_zero) begin
          cap       = 1'b1;
          state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        // Ack beats replacement, which beats withdrawal.
        if (core_int_ack)
          state_nxt = ST_CLEAR;
        else if (sel_vld && !enc_zero && sel_prio > int_prio && sel_onehot != hold_oh)
          cap = 1'b1;
        else if (!sel_vld || (sel_onehot & hold_oh) != hold_oh)
          state_nxt = ST_IDLE;
      end
      ST_CLEAR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clic_clk) begin
    if (clic_rst) begin
      state      <= ST_IDLE;
      int_id     <= '0;
      int_prio   <= '0;
      hold_oh    <= '0;
      onehot_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (cap) begin
        int_id   <= enc_id;
        int_prio <= sel_prio;
        hold_oh  <= sel_onehot;
      end
      if (sel_vld && (enc_zero || enc_multi))
        onehot_err <= 1'b1;
    end
  end

  assign int_vld         = (state == ST_PEND);
  assign pend_clr_onehot = (state == ST_CLEAR) ? hold_oh : '0;

endmodule

// File: tb/tb_cr_clic_sel_claim.sv
// Bench for cr_clic_sel_claim: directed scenarios plus randomized traffic
// against a cycle-level behavioural model.
module tb_cr_clic_sel_claim;

  localparam int WIDTH  = 32;
  localparam int ID_W   = 5;
  localparam int PRIO_W = 8;

  logic              clic_clk = 1'b0;
  logic              clic_rst;
  logic              sel_vld;
  logic [WIDTH-1:0]  sel_onehot;
  logic [PRIO_W-1:0] sel_prio;
  logic              core_int_ack;
  logic              int_vld;
  logic [ID_W-1:0]   int_id;
  logic [PRIO_W-1:0] int_prio;
  logic [WIDTH-1:0]  pend_clr_onehot;
  logic              onehot_err;

  int checks   = 0;
  int failures = 0;

  // model state: presenting? clearing this cycle? held winner, sticky error
  bit              m_pres, m_clr, m_err;
  logic [ID_W-1:0] m_id;
  logic [PRIO_W-1:0] m_prio;
  logic [WIDTH-1:0]  m_oh;

  cr_clic_sel_claim #(.WIDTH(WIDTH), .ID_W(ID_W), .PRIO_W(PRIO_W)) dut (
    .clic_clk        (clic_clk),
    .clic_rst        (clic_rst),
    .sel_vld         (sel_vld),
    .sel_onehot      (sel_onehot),
    .sel_prio        (sel_prio),
    .core_int_ack    (core_int_ack),
    .int_vld         (int_vld),
    .int_id          (int_id),
    .int_prio        (int_prio),
    .pend_clr_onehot (pend_clr_onehot),
    .onehot_err      (onehot_err)
  );

  always #5 clic_clk = ~clic_clk;

  function automatic logic [ID_W-1:0] or_index(input logic [WIDTH-1:0] v);
    logic [ID_W-1:0] r = '0;
    for (int i = 0; i < WIDTH; i++) if (v[i]) r = r | ID_W'(i);
    return r;
  endfunction

  task automatic model_step();
    int n = $countones(sel_onehot);
    if (clic_rst) begin
      m_pres = 0; m_clr = 0; m_err = 0; m_id = '0; m_prio = '0; m_oh = '0;
    end else begin
      if (sel_vld && n != 1) m_err = 1;
      if (m_clr) m_clr = 0;
      else if (!m_pres) begin
        if (sel_vld && n > 0) begin
          m_pres = 1; m_id = or_index(sel_onehot); m_prio = sel_prio; m_oh = sel_onehot;
        end
      end else if (core_int_ack) begin
        m_pres = 0; m_clr = 1;
      end else if (sel_vld && n > 0 && sel_prio > m_prio && sel_onehot != m_oh) begin
        m_id = or_index(sel_onehot); m_prio = sel_prio; m_oh = sel_onehot;
      end else if (!sel_vld || (sel_onehot & m_oh) != m_oh)
        m_pres = 0;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clic_clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [WIDTH-1:0] oh, input logic [PRIO_W-1:0] p, input bit ack);
    sel_vld = v; sel_onehot = oh; sel_prio = p; core_int_ack = ack;
  endtask

  task automatic test_reset();
    clic_rst = 1; drive(1, 32'h8, 8'd3, 1);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({int_vld, int_id, int_prio, pend_clr_onehot, onehot_err} !== '0) begin
        failures++;
        $display("FAIL reset_outputs cyc%0d: vld=%b id=%0d prio=%0d clr=%h err=%b, want all 0",
                 c, int_vld, int_id, int_prio, pend_clr_onehot, onehot_err);
      end
    end
    clic_rst = 0; core_int_ack = 0;
    tick();
    checks++;
    if (int_vld !== 1 || int_id !== 5'd3 || int_prio !== 8'd3) begin
      failures++;
      $display("FAIL reset_first_capture: vld=%b id=%0d prio=%0d, want 1/3/3", int_vld, int_id, int_prio);
    end
    drive(0, '0, '0, 0);
    tick();
  endtask

  task automatic test_basic_claim();
    drive(1, 32'h400, 8'd5, 0);
    tick();
    checks++;
    if (int_vld !== 1 || int_id !== 5'd10 || int_prio !== 8'd5 || pend_clr_onehot !== '0) begin
      failures++;
      $display("FAIL basic_present: vld=%b id=%0d prio=%0d clr=%h, want 1/10/5/0", int_vld, int_id, int_prio, pend_clr_onehot);
    end
    tick();
    core_int_ack = 1;
    tick();
    checks++;
    if (int_vld !== 0 || pend_clr_onehot !== 32'h400) begin
      failures++;
      $display("FAIL basic_clear: vld=%b clr=%h, want 0/00000400", int_vld, pend_clr_onehot);
    end
    drive(0, '0, '0, 0);
    tick();
    checks++;
    if (int_vld !== 0 || pend_clr_onehot !== '0) begin
      failures++;
      $display("FAIL basic_pulse_len: vld=%b clr=%h, want 0/0", int_vld, pend_clr_onehot);
    end
  endtask

  task automatic test_preempt();
    drive(1, 32'h400, 8'd5, 0);
    tick();
    drive(1, 32'h1, 8'd9, 0);
    tick();
    checks++;
    if (int_vld !== 1 || int_id !== 5'd0 || int_prio !== 8'd9) begin
      failures++;
      $display("FAIL preempt_higher: vld=%b id=%0d prio=%0d, want 1/0/9", int_vld, int_id, int_prio);
    end
    drive(0, '0, '0, 0);
    tick();
    drive(1, 32'h400, 8'd5, 0);
    tick();
    // equal priority never replaces; the held source is gone so it is withdrawn
    drive(1, 32'h1, 8'd5, 0);
    tick();
    checks++;
    if (int_id !== 5'd10 || int_prio !== 8'd5 || pend_clr_onehot !== '0) begin
      failures++;
      $display("FAIL preempt_equal: id=%0d prio=%0d clr=%h, want 10/5/0", int_id, int_prio, pend_clr_onehot);
    end
    drive(0, '0, '0, 0);
    tick();
  endtask

  task automatic test_ack_vs_replace();
    drive(1, 32'h400, 8'd5, 0);
    tick();
    drive(1, 32'h1, 8'd9, 1);
    tick();
    checks++;
    if (int_vld !== 0 || pend_clr_onehot !== 32'h400) begin
      failures++;
      $display("FAIL ackrep_clear: vld=%b clr=%h, want 0/00000400", int_vld, pend_clr_onehot);
    end
    core_int_ack = 0;
    tick();
    checks++;
    if (int_vld !== 0 || pend_clr_onehot !== '0) begin
      failures++;
      $display("FAIL ackrep_gap: vld=%b clr=%h, want 0/0", int_vld, pend_clr_onehot);
    end
    tick();
    checks++;
    if (int_vld !== 1 || int_id !== 5'd0 || int_prio !== 8'd9) begin
      failures++;
      $display("FAIL ackrep_recapture: vld=%b id=%0d prio=%0d, want 1/0/9", int_vld, int_id, int_prio);
    end
    drive(0, '0, '0, 0);
    tick();
  endtask

  task automatic test_withdraw();
    drive(1, 32'h400, 8'd5, 0);
    tick();
    drive(0, '0, '0, 0);
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (int_vld !== 0 || pend_clr_onehot !== '0) begin
        failures++;
        $display("FAIL withdraw cyc%0d: vld=%b clr=%h, want 0/0", c, int_vld, pend_clr_onehot);
      end
    end
  endtask

  task automatic test_bad_input();
    checks++;
    if (onehot_err !== 0) begin
      failures++;
      $display("FAIL err_clean: err=%b, want 0", onehot_err);
    end
    drive(1, 32'h6, 8'd2, 0);
    tick();
    checks++;
    if (int_vld !== 1 || int_id !== 5'd3 || onehot_err !== 1) begin
      failures++;
      $display("FAIL multihot: vld=%b id=%0d err=%b, want 1/3/1", int_vld, int_id, onehot_err);
    end
    drive(0, '0, '0, 0);
    tick();
    checks++;
    if (onehot_err !== 1) begin
      failures++;
      $display("FAIL err_sticky: err=%b, want 1", onehot_err);
    end
    drive(1, '0, 8'd7, 0);
    tick();
    checks++;
    if (int_vld !== 0 || onehot_err !== 1) begin
      failures++;
      $display("FAIL zero_vec: vld=%b err=%b, want 0/1", int_vld, onehot_err);
    end
    drive(0, '0, '0, 0);
    clic_rst = 1;
    tick();
    clic_rst = 0;
    checks++;
    if (onehot_err !== 0) begin
      failures++;
      $display("FAIL err_reset: err=%b, want 0", onehot_err);
    end
  endtask

  task automatic test_back_to_back();
    int claims = 0;
    drive(1, 32'h20, 8'd4, 1);
    for (int c = 0; c < 9; c++) begin
      tick();
      if (pend_clr_onehot == 32'h20) claims++;
      checks++;
      if (int_vld !== m_pres || pend_clr_onehot !== (m_clr ? m_oh : '0)) begin
        failures++;
        $display("FAIL b2b cyc%0d: vld=%b clr=%h, want %b/%h", c, int_vld, pend_clr_onehot, m_pres, m_clr ? m_oh : '0);
      end
    end
    checks++;
    if (claims != 3) begin
      failures++;
      $display("FAIL b2b_claims: got %0d clear pulses in 9 cycles, want 3", claims);
    end
    drive(0, '0, '0, 0);
    tick();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] oh;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(9))
        0:       oh = '0;
        1:       oh = (WIDTH'(1) << $urandom_range(7)) | (WIDTH'(1) << $urandom_range(7));
        default: oh = WIDTH'(1) << $urandom_range(7);
      endcase
      clic_rst = ($urandom_range(99) == 0);
      drive($urandom_range(3) != 0, oh, PRIO_W'($urandom_range(7)), $urandom_range(3) == 0);
      tick();
      checks++;
      if (int_vld !== m_pres || pend_clr_onehot !== (m_clr ? m_oh : '0) || onehot_err !== m_err ||
          (m_pres && (int_id !== m_id || int_prio !== m_prio))) begin
        failures++;
        $display("FAIL random cyc%0d: vld=%b id=%0d prio=%0d clr=%h err=%b, want %b/%0d/%0d/%h/%b",
                 c, int_vld, int_id, int_prio, pend_clr_onehot, onehot_err,
                 m_pres, m_id, m_prio, m_clr ? m_oh : '0, m_err);
      end
    end
    clic_rst = 0;
    drive(0, '0, '0, 0);
    tick();
  endtask

  initial begin
    clic_rst = 1;
    drive(0, '0, '0, 0);
    test_reset();
    test_basic_claim();
    test_preempt();
    test_ack_vs_replace();
    test_withdraw();
    test_bad_input();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
